// File: rtl/led_frame_loader.sv
// Double-buffered LED frame loader: row words stream into a back buffer, then the whole frame swaps to the front.
// Latency: the front buffer updates 1 edge after the last-word accept, or on the first i_frame_tick after it (SYNC_SWAP=1).
// Backpressure: o_ready is a registered state decode, held low while a completed frame waits to swap.
module led_frame_loader #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8,
    parameter int SYNC_SWAP      = 1
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_COLS-1:0]          i_data,
    input  logic                         i_frame_start,
    input  logic                         i_frame_tick,
    output logic [NUM_ROWS*NUM_COLS-1:0] o_rows_flat,
    output logic [NUM_ROWS_WIDTH-1:0]    o_row_ptr,
    output logic                         o_swap
);

    typedef enum logic {
        ST_LOAD,
        ST_WAIT_SWAP
    } state_t;

    localparam logic [NUM_ROWS_WIDTH-1:0] LAST_ROW = NUM_ROWS_WIDTH'(NUM_ROWS - 1);
    localparam logic [NUM_ROWS_WIDTH-1:0] PTR_ONE  = NUM_ROWS_WIDTH'(1);

    state_t                         state_q, state_d;
    logic [NUM_ROWS_WIDTH-1:0]      ptr_q, ptr_d;
    logic [NUM_ROWS*NUM_COLS-1:0]   back_q, back_d;
    logic [NUM_ROWS*NUM_COLS-1:0]   front_q, front_d;
    logic                           swap_q, swap_d;
    logic                           accept;
    logic [NUM_ROWS_WIDTH-1:0]      ptr_sel;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        back_d  = back_q;
        front_d = front_q;
        swap_d  = 1'b0;
        accept  = i_valid && (state_q == ST_LOAD);
        // A frame-start that coincides with an accept retargets this word to row 0.
        ptr_sel = i_frame_start ? '0 : ptr_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        if (ptr_sel == NUM_ROWS_WIDTH'(r)) begin
                            back_d[r*NUM_COLS +: NUM_COLS] = i_data;
                        end
                    end
                    if (ptr_sel == LAST_ROW) begin
                        state_d = ST_WAIT_SWAP;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_sel + PTR_ONE;
                    end
                end else if (i_frame_start) begin
                    ptr_d = '0;
                end
            end
            ST_WAIT_SWAP: begin
                // Ticks only count once the frame is complete, so a tick on the last-word edge is skipped.
                if ((SYNC_SWAP == 0) || i_frame_tick) begin
                    front_d = back_q;
                    swap_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            back_q  <= '0;
            front_q <= '0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            back_q  <= back_d;
            front_q <= front_d;
            swap_q  <= swap_d;
        end
    end

    assign o_ready     = (state_q == ST_LOAD);
    assign o_rows_flat = front_q;
    assign o_row_ptr   = ptr_q;
    assign o_swap      = swap_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: immediate-swap and tick-synchronised instances share one stimulus bus.
`timescale 1ns/1ps
module tb_led_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        fstart = 1'b0;
    logic        tick = 1'b0;

    logic        s0_rdy, s1_rdy, s0_swap, s1_swap;
    logic [31:0] s0_rows, s1_rows;
    logic [1:0]  s0_ptr, s1_ptr;

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b0;

    always #41.667 clk = ~clk;

    led_frame_loader #(.NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(8), .SYNC_SWAP(0)) u_s0 (
        .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s0_rdy), .i_data(data),
        .i_frame_start(fstart), .i_frame_tick(tick), .o_rows_flat(s0_rows),
        .o_row_ptr(s0_ptr), .o_swap(s0_swap)
    );

    led_frame_loader #(.NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(8), .SYNC_SWAP(1)) u_s1 (
        .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s1_rdy), .i_data(data),
        .i_frame_start(fstart), .i_frame_tick(tick), .o_rows_flat(s1_rows),
        .o_row_ptr(s1_ptr), .o_swap(s1_swap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic cur_rdy();
        return sel ? s1_rdy : s0_rdy;
    endfunction
    function automatic logic cur_swap();
        return sel ? s1_swap : s0_swap;
    endfunction
    function automatic logic [31:0] cur_rows();
        return sel ? s1_rows : s0_rows;
    endfunction
    function automatic logic [1:0] cur_ptr();
        return sel ? s1_ptr : s0_ptr;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        valid  = 1'b0;
        data   = 8'h00;
        fstart = 1'b0;
        tick   = 1'b0;
        rst_n  = 1'b0;
        #5;
        chk({tag, "_rst_rows"}, cur_rows(), 32'h0);
        chk({tag, "_rst_ptr"}, {30'd0, cur_ptr()}, 32'd0);
        chk({tag, "_rst_rdy"}, {31'd0, cur_rdy()}, 32'd1);
        chk({tag, "_rst_swap"}, {31'd0, cur_swap()}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(input logic [7:0] d, input logic f, input logic t);
        int n;
        n = 0;
        while (!cur_rdy() && n < 50) begin
            step();
            n++;
        end
        if (!cur_rdy()) chk("send_rdy_timeout", 32'd0, 32'd1);
        valid  = 1'b1;
        data   = d;
        fstart = f;
        tick   = t;
        step();
        valid  = 1'b0;
        data   = 'x;
        fstart = 1'b0;
        tick   = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // 1: immediate swap
        sel = 1'b0;
        do_reset("t1");
        send(8'h0F, 0, 0); send(8'hF0, 0, 0); send(8'hCC, 0, 0); send(8'hAA, 0, 0);
        chk("t1_rdy_low", {31'd0, cur_rdy()}, 32'd0);
        chk("t1_rows_hold", cur_rows(), 32'h0);
        chk("t1_swap_early", {31'd0, cur_swap()}, 32'd0);
        step();
        chk("t1_rows", cur_rows(), 32'hAACCF00F);
        chk("t1_swap", {31'd0, cur_swap()}, 32'd1);
        chk("t1_rdy_back", {31'd0, cur_rdy()}, 32'd1);
        step();
        chk("t1_swap_once", {31'd0, cur_swap()}, 32'd0);
        chk("t1_rows_stable", cur_rows(), 32'hAACCF00F);

        // 2: tick-synchronised swap
        sel = 1'b1;
        do_reset("t2");
        send(8'h0F, 0, 0); send(8'hF0, 0, 0); send(8'hCC, 0, 0); send(8'hAA, 0, 0);
        chk("t2_rdy_low", {31'd0, cur_rdy()}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t2_wait_rows", cur_rows(), 32'h0);
            chk("t2_wait_rdy", {31'd0, cur_rdy()}, 32'd0);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t2_rows", cur_rows(), 32'hAACCF00F);
        chk("t2_swap", {31'd0, cur_swap()}, 32'd1);
        step();
        chk("t2_swap_once", {31'd0, cur_swap()}, 32'd0);

        // 3: abort a partial frame
        sel = 1'b0;
        do_reset("t3");
        send(8'h11, 0, 0); send(8'h22, 0, 0);
        chk("t3_ptr_partial", {30'd0, cur_ptr()}, 32'd2);
        fstart = 1'b1;
        step();
        fstart = 1'b0;
        chk("t3_ptr_abort", {30'd0, cur_ptr()}, 32'd0);
        chk("t3_no_swap", {31'd0, cur_swap()}, 32'd0);
        send(8'h0F, 0, 0); send(8'hF0, 0, 0);
        chk("t3_ptr_mid", {30'd0, cur_ptr()}, 32'd2);
        chk("t3_rows_mid", cur_rows(), 32'h0);
        send(8'hCC, 0, 0); send(8'hAA, 0, 0);
        step();
        chk("t3_rows", cur_rows(), 32'hAACCF00F);

        // 4: gapped valid, valid held through the swap wait
        sel = 1'b1;
        do_reset("t4");
        begin
            logic [7:0]  words [8];
            logic [31:0] exp_fr [2];
            int i, nsw, wcnt, cyc;
            logic acc;
            words  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
            exp_fr = '{32'h04030201, 32'h40302010};
            i = 0; nsw = 0; wcnt = 0; cyc = 0;
            while ((i < 8 || nsw < 2) && cyc < 400) begin
                if (s1_swap) begin
                    if (nsw < 2) chk($sformatf("t4_frame%0d", nsw), s1_rows, exp_fr[nsw]);
                    nsw++;
                end
                tick = 1'b0;
                if (!s1_rdy) begin
                    wcnt++;
                    if (wcnt == 3) tick = 1'b1;
                end else begin
                    wcnt = 0;
                end
                if (i < 8) begin
                    valid = s1_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                    data  = valid ? words[i] : 'x;
                end else begin
                    valid = 1'b0;
                    data  = 'x;
                end
                acc = valid && s1_rdy;
                if (acc) chk($sformatf("t4_ptr%0d", i), {30'd0, s1_ptr}, i % 4);
                step();
                if (acc) i++;
                cyc++;
            end
            valid = 1'b0;
            tick  = 1'b0;
            chk("t4_words", i, 8);
            chk("t4_swaps", nsw, 2);
            chk("t4_ptr_end", {30'd0, s1_ptr}, 32'd0);
            chk("t4_rows_end", s1_rows, 32'h40302010);
        end

        // 5: async reset mid-frame
        sel = 1'b0;
        do_reset("t5");
        send(8'h0F, 0, 0); send(8'hF0, 0, 0); send(8'hCC, 0, 0); send(8'hAA, 0, 0);
        step();
        chk("t5_rows_f1", cur_rows(), 32'hAACCF00F);
        send(8'h12, 0, 0); send(8'h34, 0, 0);
        chk("t5_ptr_mid", {30'd0, cur_ptr()}, 32'd2);
        #10;
        rst_n = 1'b0;
        #1;
        chk("t5_rows_cleared", cur_rows(), 32'h0);
        chk("t5_ptr_cleared", {30'd0, cur_ptr()}, 32'd0);
        chk("t5_rdy_cleared", {31'd0, cur_rdy()}, 32'd1);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        send(8'h5A, 0, 0); send(8'hA5, 0, 0); send(8'h3C, 0, 0); send(8'hC3, 0, 0);
        step();
        chk("t5_rows_clean", cur_rows(), 32'hC33CA55A);
        chk("t5_swap", {31'd0, cur_swap()}, 32'd1);

        // 6: frame-start with accept, ticks in LOAD and on the last-word edge
        sel = 1'b1;
        do_reset("t6");
        send(8'h99, 0, 0); send(8'h77, 0, 0);
        chk("t6_ptr_pre", {30'd0, cur_ptr()}, 32'd2);
        send(8'h55, 1, 0);
        chk("t6_ptr_fs", {30'd0, cur_ptr()}, 32'd1);
        send(8'h66, 0, 1);
        chk("t6_tick_load_swap", {31'd0, cur_swap()}, 32'd0);
        chk("t6_ptr2", {30'd0, cur_ptr()}, 32'd2);
        send(8'h44, 0, 0);
        send(8'h33, 0, 1);
        chk("t6_rdy_low", {31'd0, cur_rdy()}, 32'd0);
        chk("t6_collide_swap", {31'd0, cur_swap()}, 32'd0);
        chk("t6_collide_rows", cur_rows(), 32'h0);
        repeat (3) step();
        chk("t6_wait_swap", {31'd0, cur_swap()}, 32'd0);
        chk("t6_wait_rows", cur_rows(), 32'h0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t6_rows", cur_rows(), 32'h33446655);
        chk("t6_swap", {31'd0, cur_swap()}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
